// File: rtl/fsm_monitor_if.sv
// Bundle between the lab sequencer's state stream and the passive fsm_monitor.
// master is the observing top level; slave is the monitor itself.
interface fsm_monitor_if;
  logic [3:0] state_in;
  logic       step;
  logic       err;
  logic       err_sticky;
  logic [3:0] err_from;
  logic [3:0] err_to;
  logic       d1_valid;
  logic [1:0] d1_code;
  logic       d2_valid;
  logic       d2_code;
  logic [7:0] lap_count;
  logic       stall;
  logic       dbg_phase;
  logic [3:0] dbg_prev;

  modport master (
    output state_in,
    input  step, err, err_sticky, err_from, err_to,
    input  d1_valid, d1_code, d2_valid, d2_code,
    input  lap_count, stall, dbg_phase, dbg_prev
  );

  modport slave (
    input  state_in,
    output step, err, err_sticky, err_from, err_to,
    output d1_valid, d1_code, d2_valid, d2_code,
    output lap_count, stall, dbg_phase, dbg_prev
  );
endinterface

// File: rtl/fsm_monitor.sv
// Passive checker/decoder for the lab sequencer state stream: validates each
// transition, decodes the state-3/state-10 dispatches, counts laps, flags stalls.
module fsm_monitor #(
  parameter logic [31:0] DWELL_MAX = 32'd100_000_001
) (
  input logic          clk,
  input logic          rst_n,
  fsm_monitor_if.slave bus
);

  // PH_CAPTURE: first cycle after reset, sample taken without a check.
  typedef enum logic {
    PH_CAPTURE = 1'b0,
    PH_RUN     = 1'b1
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [3:0]  prev_q, prev_d;
  logic [31:0] dwell_q, dwell_d;
  logic        step_q, step_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;
  logic [3:0]  from_q, from_d;
  logic [3:0]  to_q, to_d;
  logic        d1v_q, d1v_d;
  logic [1:0]  d1c_q, d1c_d;
  logic        d2v_q, d2v_d;
  logic        d2c_q, d2c_d;
  logic [7:0]  lap_q, lap_d;
  logic        stall_q, stall_d;

  logic [3:0]  s;
  logic        change;
  logic        legal;
  logic        out_of_range;

  assign s            = bus.state_in;
  assign change       = (phase_q == PH_RUN) && (s != prev_q);
  assign out_of_range = (s > 4'd12);

  // Sequencer microcode: sequential steps plus the two dispatch fan-outs.
  always_comb begin
    legal = 1'b0;
    case (prev_q)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9: legal = (s == prev_q + 4'd1);
      4'd3:        legal = (s == 4'd4) || (s == 4'd5) || (s == 4'd6);
      4'd4, 4'd5:  legal = (s == 4'd7);
      4'd10:       legal = (s == 4'd11) || (s == 4'd12);
      4'd11, 4'd12: legal = (s == 4'd0);
      default:     legal = 1'b0;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_CAPTURE: phase_d = PH_RUN;
      PH_RUN:     phase_d = PH_RUN;
      default:    phase_d = PH_CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_CAPTURE;
    else        phase_q <= phase_d;
  end

  always_comb begin
    prev_d   = prev_q;
    dwell_d  = dwell_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;
    from_d   = from_q;
    to_d     = to_q;
    d1v_d    = 1'b0;
    d1c_d    = d1c_q;
    d2v_d    = 1'b0;
    d2c_d    = d2c_q;
    lap_d    = lap_q;

    if (phase_q == PH_CAPTURE) begin
      prev_d = s;
      // A first sample outside 0..12 is reported with 4'hF as its source.
      if (out_of_range) begin
        err_d = 1'b1;
        if (!sticky_q) begin
          sticky_d = 1'b1;
          from_d   = 4'hF;
          to_d     = s;
        end
      end
    end else if (change) begin
      prev_d = s;
      if (legal) begin
        step_d = 1'b1;
        if (prev_q == 4'd3) begin
          d1v_d = 1'b1;
          d1c_d = 2'(s - 4'd4);
        end
        if (prev_q == 4'd10) begin
          d2v_d = 1'b1;
          d2c_d = (s == 4'd12);
        end
        if (s == 4'd0) lap_d = lap_q + 8'd1;
      end else begin
        err_d = 1'b1;
        if (!sticky_q) begin
          sticky_d = 1'b1;
          from_d   = prev_q;
          to_d     = s;
        end
      end
    end

    if (change)                     dwell_d = 32'd0;
    else if (dwell_q != DWELL_MAX)  dwell_d = dwell_q + 32'd1;

    stall_d = (dwell_d == DWELL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 4'd0;
      dwell_q  <= 32'd0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      from_q   <= 4'd0;
      to_q     <= 4'd0;
      d1v_q    <= 1'b0;
      d1c_q    <= 2'd0;
      d2v_q    <= 1'b0;
      d2c_q    <= 1'b0;
      lap_q    <= 8'd0;
      stall_q  <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      dwell_q  <= dwell_d;
      step_q   <= step_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      from_q   <= from_d;
      to_q     <= to_d;
      d1v_q    <= d1v_d;
      d1c_q    <= d1c_d;
      d2v_q    <= d2v_d;
      d2c_q    <= d2c_d;
      lap_q    <= lap_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.step       = step_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_from   = from_q;
  assign bus.err_to     = to_q;
  assign bus.d1_valid   = d1v_q;
  assign bus.d1_code    = d1c_q;
  assign bus.d2_valid   = d2v_q;
  assign bus.d2_code    = d2c_q;
  assign bus.lap_count  = lap_q;
  assign bus.stall      = stall_q;
  assign bus.dbg_phase  = (phase_q == PH_RUN);
  assign bus.dbg_prev   = prev_q;

endmodule
